// File: rtl/evo_circuit_evaluator.sv
// Reconfigurable gate-array evaluator: serial genome, registered gates, exhaustive input sweep and scoring.
// Optional OSC_DETECT_EN: flags vectors whose output moves between the last settle cycle and sample.
module evo_gate (
  input  logic [2:0] func,
  input  logic       a,
  input  logic       b,
  output logic       y
);
  always_comb begin
    y = a;
    case (func)
      3'd0: y = a & b;
      3'd1: y = a | b;
      3'd2: y = ~(a & b);
      3'd3: y = ~(a | b);
      3'd4: y = a ^ b;
      3'd5: y = ~(a ^ b);
      3'd6: y = ~a;
      default: y = a;
    endcase
  end
endmodule

module evo_circuit_evaluator #(
  parameter int NUM_INPUTS    = 4,
  parameter int NUM_GATES     = 7,
  parameter int SETTLE_CYCLES = 4,
  localparam int SEL_W    = $clog2(NUM_INPUTS + NUM_GATES),
  localparam int GENE_W   = 3 + 2 * SEL_W,
  localparam int GENOME_W = NUM_GATES * GENE_W + SEL_W,
  localparam int TT_W     = 2 ** NUM_INPUTS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_bit,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic                  start,
  input  logic [TT_W-1:0]       target,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_INPUTS:0]   fitness,
  output logic [TT_W-1:0]       truth_table,
  output logic [NUM_INPUTS:0]   unstable_cnt
);
  localparam int NSRC = 2 ** SEL_W;
  localparam int SCW  = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;
  state_t state;

  logic [GENOME_W-1:0]   genome;
  logic [NUM_GATES-1:0]  w, w_nxt;
  logic [NUM_INPUTS-1:0] vec;
  logic [SCW-1:0]        scnt;
  logic [NSRC-1:0]       srcv;
  logic                  out, stable, score;

  // Source space: inputs, then gate flops, then constant zero for out-of-range selects.
  always_comb begin
    srcv = '0;
    srcv[NUM_INPUTS-1:0] = vec;
    srcv[NUM_INPUTS +: NUM_GATES] = w;
  end

  for (genvar gi = 0; gi < NUM_GATES; gi++) begin : g_gate
    logic [GENE_W-1:0] gene;
    assign gene = genome[gi*GENE_W +: GENE_W];
    evo_gate u_gate (
      .func (gene[GENE_W-1 -: 3]),
      .a    (srcv[gene[2*SEL_W-1 -: SEL_W]]),
      .b    (srcv[gene[SEL_W-1:0]]),
      .y    (w_nxt[gi])
    );
  end

  assign out = srcv[genome[GENOME_W-1 -: SEL_W]];

`ifdef OSC_DETECT_EN
  logic                prev_out;
  logic [NUM_INPUTS:0] unst_q;
  assign stable       = (out == prev_out);
  assign unstable_cnt = unst_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_out <= 1'b0;
      unst_q   <= '0;
    end else begin
      prev_out <= out;
      if (state == IDLE && start && !cfg_valid) unst_q <= '0;
      else if (state == SAMPLE && !stable)      unst_q <= unst_q + 1'b1;
    end
  end
`else
  assign stable       = 1'b1;
  assign unstable_cnt = '0;
`endif

  assign score = stable && (out == target[vec]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      genome      <= '0;
      w           <= '0;
      vec         <= '0;
      scnt        <= '0;
      fitness     <= '0;
      truth_table <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_ready   <= 1'b1;
    end else begin
      done <= 1'b0;
      if (state != IDLE) w <= w_nxt;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            genome <= {cfg_bit, genome[GENOME_W-1:1]};
          end else if (start) begin
            w           <= '0;
            vec         <= '0;
            fitness     <= '0;
            truth_table <= '0;
            busy        <= 1'b1;
            cfg_ready   <= 1'b0;
            state       <= APPLY;
          end
        end
        APPLY: begin
          scnt  <= '0;
          state <= SETTLE;
        end
        SETTLE: begin
          if (scnt == SCW'(SETTLE_CYCLES - 1)) state <= SAMPLE;
          else scnt <= scnt + 1'b1;
        end
        SAMPLE: begin
          truth_table[vec] <= out;
          if (score) fitness <= fitness + 1'b1;
          if (&vec) begin
            state <= DONE;
          end else begin
            vec   <= vec + 1'b1;
            state <= APPLY;
          end
        end
        DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
